page_mode: RTL and testbench

PAGE_MODE -- requirements
Module: page_mode

---
 rtl/cram_pkg.sv | 49 ++++
 rtl/page_mode.sv | 119 +++++++++++
 tb/tb_page_mode.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_pkg.sv
// Shared definitions for the CellularRAM asynchronous page-mode reader:
// state codes, control-bus bit positions and timing defaults.
package cram_pkg;

  // State codes; these values are what COUT_STATUS reports.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_WAIT_INIT = 4'd2,
    ST_CAPTURE   = 4'd3,
    ST_WAIT_PAGE = 4'd4,
    ST_DONE      = 4'd5
  } state_e;

  // Bit positions inside COUT_CRAM.
  localparam int CRAM_CE_N  = 0;
  localparam int CRAM_OE_N  = 1;
  localparam int CRAM_WE_N  = 2;
  localparam int CRAM_ADV_N = 3;
  localparam int CRAM_UB_N  = 4;
  localparam int CRAM_LB_N  = 5;
  localparam int CRAM_CRE   = 6;
  localparam int CRAM_CLK   = 7;

  // Timing defaults in Clock cycles (20 ns clock).
  localparam int unsigned T_INIT_DEFAULT = 4;
  localparam int unsigned T_PAGE_DEFAULT = 2;

  // Control pattern presented while reset is held.
  localparam logic [7:0] CRAM_RESET = 8'h3B;

  // Control pattern in normal operation. WE_n, ADV_n, CRE and CRAM_CLK are
  // tied so the device stays in asynchronous page mode; the chip/output/byte
  // enables follow whether a read access is in progress.
  function automatic logic [7:0] cram_ctrl(input logic active);
    logic [7:0] c;
    c             = 8'h00;
    c[CRAM_CE_N]  = ~active;
    c[CRAM_OE_N]  = ~active;
    c[CRAM_WE_N]  = 1'b1;
    c[CRAM_ADV_N] = 1'b0;
    c[CRAM_UB_N]  = ~active;
    c[CRAM_LB_N]  = ~active;
    c[CRAM_CRE]   = 1'b0;
    c[CRAM_CLK]   = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/page_mode.sv
// Asynchronous page-mode burst reader for a CellularRAM. A start request
// latches a word address and length; the block then reads 1..8 words from
// the same 16-word page, emitting one FIFO write strobe per word and a
// done pulse at the end. All outputs are registered.
module page_mode
  import cram_pkg::*;
#(
  parameter int unsigned T_INIT = T_INIT_DEFAULT,
  parameter int unsigned T_PAGE = T_PAGE_DEFAULT
) (
  input  logic        Clock,
  input  logic        aReset,
  input  logic [21:0] DIN_Address,
  input  logic [2:0]  DIN_Length,
  input  logic        CIN_PM,
  output logic [22:0] DOUT_ADDR,
  output logic [15:0] DOUT_CPU,
  output logic [7:0]  COUT_CRAM,
  output logic        COUT_OUTFIFO,
  output logic [3:0]  COUT_STATUS,
  output logic        COUT_PM,
  inout  wire  [15:0] DIO_CRAM
);

  // Wait-counter reload values: a wait state of L cycles counts L-1 down to 0.
  localparam logic [7:0] INIT_LOAD = (T_INIT > 1) ? 8'(T_INIT - 2) : 8'd0;
  localparam logic [7:0] PAGE_LOAD = (T_PAGE > 1) ? 8'(T_PAGE - 2) : 8'd0;

  state_e      state_q, state_d;
  logic [21:0] addr_q;
  logic [2:0]  rem_q;
  logic [7:0]  wait_q;
  logic [15:0] data_q;
  logic        fifo_q;
  logic        pm_q;
  logic [7:0]  cram_q;
  logic        active_d;

  // The block only ever reads the RAM bus.
  assign DIO_CRAM = 16'hzzzz;

  assign DOUT_ADDR    = {1'b0, addr_q};
  assign DOUT_CPU     = data_q;
  assign COUT_CRAM    = cram_q;
  assign COUT_OUTFIFO = fifo_q;
  assign COUT_STATUS  = state_q;
  assign COUT_PM      = pm_q;

  // Next-state selection; wait states with a length of zero are skipped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (CIN_PM) state_d = ST_START;
      ST_START:     state_d = (T_INIT > 1) ? ST_WAIT_INIT : ST_CAPTURE;
      ST_WAIT_INIT: if (wait_q == 8'd0) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (rem_q == 3'd0)  state_d = ST_DONE;
        else if (T_PAGE > 1) state_d = ST_WAIT_PAGE;
        else                 state_d = ST_CAPTURE;
      end
      ST_WAIT_PAGE: if (wait_q == 8'd0) state_d = ST_CAPTURE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // RAM enables are asserted for every state between START and WAIT_PAGE.
  always_comb begin
    active_d = (state_d == ST_START)   || (state_d == ST_WAIT_INIT) ||
               (state_d == ST_CAPTURE) || (state_d == ST_WAIT_PAGE);
  end

  // FSM state, datapath counters and registered outputs.
  always_ff @(posedge Clock) begin
    if (aReset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      fifo_q  <= 1'b0;
      pm_q    <= 1'b0;
      cram_q  <= CRAM_RESET;
    end else begin
      state_q <= state_d;
      // Strobes are registered outputs of the state that produced them, so
      // FIFO write appears with the new data and done follows the last word.
      fifo_q  <= (state_q == ST_CAPTURE);
      pm_q    <= (state_q == ST_DONE);
      // Controls are computed from the next state so they line up with it.
      cram_q  <= cram_ctrl(active_d);
      case (state_q)
        ST_IDLE: begin
          if (CIN_PM) begin
            addr_q <= DIN_Address;
            rem_q  <= DIN_Length;
          end
        end
        ST_START: begin
          wait_q <= INIT_LOAD;
        end
        ST_WAIT_INIT, ST_WAIT_PAGE: begin
          if (wait_q != 8'd0) wait_q <= wait_q - 8'd1;
        end
        ST_CAPTURE: begin
          data_q <= DIO_CRAM;
          if (rem_q != 3'd0) begin
            rem_q       <= rem_q - 3'd1;
            // Page-mode access only wraps within the 16-word page.
            addr_q[3:0] <= addr_q[3:0] + 4'd1;
            wait_q      <= PAGE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_page_mode.sv
// Self-checking bench for page_mode: directed bursts plus randomized bursts
// checked against a cycle-count model of the burst timing and addressing.
module tb_page_mode;

  localparam int T_INIT = 4;
  localparam int T_PAGE = 2;

  logic        Clock = 1'b0;
  logic        aReset;
  logic [21:0] DIN_Address;
  logic [2:0]  DIN_Length;
  logic        CIN_PM;
  logic [22:0] DOUT_ADDR;
  logic [15:0] DOUT_CPU;
  logic [7:0]  COUT_CRAM;
  logic        COUT_OUTFIFO;
  logic [3:0]  COUT_STATUS;
  logic        COUT_PM;
  wire  [15:0] DIO_CRAM;
  logic [15:0] bus_val;

  int n_checks = 0;
  int n_fail   = 0;

  // Last value the model expects DOUT_CPU to hold.
  logic [15:0] model_data;

  assign DIO_CRAM = bus_val;

  always #10 Clock = ~Clock;

  page_mode #(.T_INIT(T_INIT), .T_PAGE(T_PAGE)) dut (
    .Clock        (Clock),
    .aReset       (aReset),
    .DIN_Address  (DIN_Address),
    .DIN_Length   (DIN_Length),
    .CIN_PM       (CIN_PM),
    .DOUT_ADDR    (DOUT_ADDR),
    .DOUT_CPU     (DOUT_CPU),
    .COUT_CRAM    (COUT_CRAM),
    .COUT_OUTFIFO (COUT_OUTFIFO),
    .COUT_STATUS  (COUT_STATUS),
    .COUT_PM      (COUT_PM),
    .DIO_CRAM     (DIO_CRAM)
  );

  task automatic test_reset();
    @(negedge Clock);
    aReset = 1'b1;
    CIN_PM = 1'b1;
    @(negedge Clock);
    n_checks++;
    if (COUT_CRAM !== 8'h3B) begin
      n_fail++; $display("FAIL reset_cram got=%h exp=3b", COUT_CRAM);
    end
    n_checks++;
    if (COUT_STATUS !== 4'd0) begin
      n_fail++; $display("FAIL reset_status got=%0d exp=0", COUT_STATUS);
    end
    n_checks++;
    if ({COUT_OUTFIFO, COUT_PM} !== 2'b00) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=00", {COUT_OUTFIFO, COUT_PM});
    end
    n_checks++;
    if (DOUT_ADDR !== 23'd0 || DOUT_CPU !== 16'd0) begin
      n_fail++; $display("FAIL reset_data got addr=%h cpu=%h exp=0", DOUT_ADDR, DOUT_CPU);
    end
    n_checks++;
    if (DIO_CRAM !== bus_val) begin
      n_fail++; $display("FAIL reset_bus got=%h exp=%h", DIO_CRAM, bus_val);
    end
    aReset = 1'b0;
    CIN_PM = 1'b0;
    model_data = 16'd0;
    @(negedge Clock);
    n_checks++;
    if (COUT_CRAM !== 8'h37 || COUT_STATUS !== 4'd0) begin
      n_fail++; $display("FAIL idle_after_reset got cram=%h st=%0d exp cram=37 st=0", COUT_CRAM, COUT_STATUS);
    end
    $display("reset: cram=%h status=%0d", COUT_CRAM, COUT_STATUS);
  endtask

  // One complete burst. Sample index t is taken on the falling edge after
  // the t-th rising edge counted from the edge that accepted the request.
  // poke_at >= 0 re-asserts CIN_PM (with different operands) for one cycle.
  task automatic run_burst(input logic [21:0] a, input logic [2:0] l,
                           input int poke_at, input string name);
    int n, p0, p_last, horizon, k, exp_st, errs0;
    logic [15:0] drv [0:63];
    logic [22:0] addr_s [0:63];
    logic [21:0] exp_addr;
    logic [3:0]  lo;
    logic        is_pulse, exp_active;
    logic [7:0]  exp_cram;
    n       = int'(l) + 1;
    p0      = T_INIT + 1;
    p_last  = p0 + T_PAGE * (n - 1);
    horizon = p_last + 2;
    errs0   = n_fail;
    @(negedge Clock);
    DIN_Address = a;
    DIN_Length  = l;
    CIN_PM      = 1'b1;
    bus_val     = 16'($urandom);
    for (int t = 0; t <= horizon; t++) begin
      @(negedge Clock);
      addr_s[t] = DOUT_ADDR;
      is_pulse  = 1'b0;
      k         = 0;
      if (t >= p0 && ((t - p0) % T_PAGE) == 0 && ((t - p0) / T_PAGE) < n) begin
        is_pulse = 1'b1;
        k        = (t - p0) / T_PAGE;
      end
      n_checks++;
      if (COUT_OUTFIFO !== is_pulse) begin
        n_fail++; $display("FAIL %s outfifo t=%0d got=%b exp=%b", name, t, COUT_OUTFIFO, is_pulse);
      end
      if (is_pulse) begin
        model_data = drv[t-1];
        lo         = a[3:0] + 4'(k);
        exp_addr   = {a[21:4], lo};
        n_checks++;
        if (addr_s[t-1] !== {1'b0, exp_addr}) begin
          n_fail++; $display("FAIL %s addr word=%0d got=%h exp=%h", name, k, addr_s[t-1], {1'b0, exp_addr});
        end
      end
      n_checks++;
      if (DOUT_CPU !== model_data) begin
        n_fail++; $display("FAIL %s cpu_data t=%0d got=%h exp=%h", name, t, DOUT_CPU, model_data);
      end
      n_checks++;
      if (COUT_PM !== (t == p_last + 1)) begin
        n_fail++; $display("FAIL %s pm t=%0d got=%b exp=%b", name, t, COUT_PM, (t == p_last + 1));
      end
      exp_active = (t < p_last);
      exp_cram   = exp_active ? 8'h04 : 8'h37;
      n_checks++;
      if (COUT_CRAM !== exp_cram) begin
        n_fail++; $display("FAIL %s cram t=%0d got=%h exp=%h", name, t, COUT_CRAM, exp_cram);
      end
      if (t == 0)                                           exp_st = 1;
      else if (t > p_last)                                  exp_st = 0;
      else if (t == p_last)                                 exp_st = 5;
      else if (t + 1 >= p0 && ((t + 1 - p0) % T_PAGE) == 0) exp_st = 3;
      else if (t < p0)                                      exp_st = 2;
      else                                                  exp_st = 4;
      n_checks++;
      if (COUT_STATUS !== 4'(exp_st)) begin
        n_fail++; $display("FAIL %s status t=%0d got=%0d exp=%0d", name, t, COUT_STATUS, exp_st);
      end
      n_checks++;
      if (DIO_CRAM !== bus_val) begin
        n_fail++; $display("FAIL %s bus t=%0d got=%h exp=%h", name, t, DIO_CRAM, bus_val);
      end
      // Drive the inputs seen at the next rising edge.
      CIN_PM = (t == poke_at);
      if (t == poke_at) begin
        DIN_Address = ~a;
        DIN_Length  = ~l;
      end
      bus_val = 16'($urandom);
      drv[t]  = bus_val;
    end
    CIN_PM = 1'b0;
    $display("burst %s: addr=%h len=%0d words=%0d last_data=%h errors=%0d",
             name, a, l, n, model_data, n_fail - errs0);
  endtask

  task automatic test_full_burst();
    run_burst(22'h000000, 3'd7, -1, "full");
  endtask

  task automatic test_single_word();
    run_burst(22'h000123, 3'd0, -1, "single");
  endtask

  task automatic test_page_wrap();
    run_burst(22'h03FFFE, 3'd3, -1, "wrap");
  endtask

  // CIN_PM raised while in WAIT_PAGE (sample T_INIT+1) must not disturb the
  // burst nor start another one afterwards.
  task automatic test_busy_ignore();
    run_burst(22'h0ABCD3, 3'd3, T_INIT + 1, "busy");
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      n_checks++;
      if (COUT_STATUS !== 4'd0 || COUT_OUTFIFO !== 1'b0 || COUT_PM !== 1'b0) begin
        n_fail++; $display("FAIL busy_restart i=%0d got st=%0d fifo=%b pm=%b exp 0", i, COUT_STATUS, COUT_OUTFIFO, COUT_PM);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge Clock);
    DIN_Address = 22'h155555;
    DIN_Length  = 3'd5;
    CIN_PM      = 1'b1;
    @(negedge Clock);
    CIN_PM = 1'b0;
    @(negedge Clock);
    n_checks++;
    if (COUT_STATUS !== 4'd2) begin
      n_fail++; $display("FAIL midreset_pre got st=%0d exp=2", COUT_STATUS);
    end
    aReset = 1'b1;
    @(negedge Clock);
    aReset = 1'b0;
    model_data = 16'd0;
    n_checks++;
    if (COUT_STATUS !== 4'd0 || COUT_CRAM[0] !== 1'b1) begin
      n_fail++; $display("FAIL midreset_idle got st=%0d ce_n=%b exp st=0 ce_n=1", COUT_STATUS, COUT_CRAM[0]);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge Clock);
      n_checks++;
      if (COUT_OUTFIFO !== 1'b0 || COUT_PM !== 1'b0 || COUT_STATUS !== 4'd0 || DOUT_CPU !== model_data) begin
        n_fail++; $display("FAIL midreset_quiet i=%0d got fifo=%b pm=%b st=%0d cpu=%h exp 0", i, COUT_OUTFIFO, COUT_PM, COUT_STATUS, DOUT_CPU);
      end
    end
    $display("reset mid-burst: status=%0d", COUT_STATUS);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      run_burst(22'($urandom), 3'($urandom_range(0, 7)), -1, "random");
    end
  endtask

  initial begin
    aReset      = 1'b1;
    CIN_PM      = 1'b0;
    DIN_Address = '0;
    DIN_Length  = '0;
    bus_val     = 16'h5A5A;
    model_data  = 16'd0;
    test_reset();
    test_full_burst();
    test_single_word();
    test_page_wrap();
    test_busy_ignore();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
